// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator and registered video output stage.
// Sits between the frame-buffer reader and the DAC/VGA pins.
//
// The pixel clock comes from an integer divider on FPGA_Clock. The pixel counters
// run one pixel ahead of the video outputs, so upstream logic has one pixel period
// to return R/G/B for the (H_COUNT, V_COUNT) it was shown.
//
// Ports:
//   FPGA_Clock         system clock
//   reset              synchronous, active-high reset
//   R, G, B            pixel colour for the counters presented on the previous tick
//   pattern_sel        1 selects the internal colour-bar pattern (VGA_TEST_PATTERN_EN builds)
//   VGA_R/G/B          registered colour, 0 while blanked
//   VGA_Clock          pixel clock to the DAC, high for the upper half of each divider period
//   VGA_HS, VGA_VS     registered syncs, active level set by HS_POL / VS_POL
//   VGA_BLANK_N        registered, 1 = visible pixel
//   VGA_SYNC_N         VGA_HS & VGA_VS
//   H_COUNT, V_COUNT   current pixel column / line
//   pixel_en           one FPGA_Clock cycle per pixel
//   line_start         pixel_en at H_COUNT == 0
//   frame_start        pixel_en at H_COUNT == 0 and V_COUNT == 0
//
// Build option: define VGA_TEST_PATTERN_EN to add eight vertical colour bars
// (white, yellow, cyan, green, magenta, red, blue, black) selected by pattern_sel.
// Without the macro pattern_sel is ignored and R/G/B always pass through.

module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CW      = 8,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW     = $clog2(H_TOT),
    localparam int unsigned VW     = $clog2(V_TOT)
) (
    input  logic          FPGA_Clock,
    input  logic          reset,
    input  logic [CW-1:0] R,
    input  logic [CW-1:0] G,
    input  logic [CW-1:0] B,
    input  logic          pattern_sel,
    output logic [CW-1:0] VGA_R,
    output logic [CW-1:0] VGA_G,
    output logic [CW-1:0] VGA_B,
    output logic          VGA_Clock,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic [HW-1:0] H_COUNT,
    output logic [VW-1:0] V_COUNT,
    output logic          pixel_en,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned DW        = $clog2(CLK_DIV);
    localparam int unsigned HS_START  = H_ACT + H_FP;
    localparam int unsigned HS_END    = H_ACT + H_FP + H_SYNC;
    localparam int unsigned VS_START  = V_ACT + V_FP;
    localparam int unsigned VS_END    = V_ACT + V_FP + V_SYNC;
    localparam int unsigned BAR_W     = H_ACT / 8;

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;
    logic          tick;
    logic          h_last;
    logic          v_last;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          visible;
    logic          hs_act;
    logic          vs_act;
    logic [CW-1:0] src_r;
    logic [CW-1:0] src_g;
    logic [CW-1:0] src_b;

    // Divider, counter next-state and video decode from the current counters
    always_comb begin
        tick     = (div == DW'(CLK_DIV - 1));
        div_next = tick ? '0 : div + DW'(1);
        h_last   = (H_COUNT == HW'(H_TOT - 1));
        v_last   = (V_COUNT == VW'(V_TOT - 1));
        h_next   = h_last ? '0 : H_COUNT + HW'(1);
        v_next   = V_COUNT;
        if (h_last) begin
            v_next = v_last ? '0 : V_COUNT + VW'(1);
        end
        visible  = (H_COUNT < HW'(H_ACT)) && (V_COUNT < VW'(V_ACT));
        hs_act   = (H_COUNT >= HW'(HS_START)) && (H_COUNT < HW'(HS_END));
        vs_act   = (V_COUNT >= VW'(VS_START)) && (V_COUNT < VW'(VS_END));
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;

    // Bar index from the column; bar bits map inversely onto the R/G/B on-flags
    always_comb begin
        bar = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (H_COUNT >= HW'(k * BAR_W)) begin
                bar = 3'(k);
            end
        end
        src_r = pattern_sel ? {CW{~bar[1]}} : R;
        src_g = pattern_sel ? {CW{~bar[2]}} : G;
        src_b = pattern_sel ? {CW{~bar[0]}} : B;
    end
`else
    logic unused_pattern_sel;

    always_comb begin
        unused_pattern_sel = pattern_sel;
        src_r              = R;
        src_g              = G;
        src_b              = B;
    end
`endif

    // Strobes are qualified by the tick so each lasts one FPGA_Clock cycle
    always_comb begin
        pixel_en    = tick;
        line_start  = tick && (H_COUNT == '0);
        frame_start = tick && (H_COUNT == '0) && (V_COUNT == '0);
        VGA_SYNC_N  = VGA_HS & VGA_VS;
    end

    // Divider, pixel counters and registered video stage
    always_ff @(posedge FPGA_Clock) begin
        if (reset) begin
            div         <= '0;
            VGA_Clock   <= 1'b0;
            H_COUNT     <= '0;
            V_COUNT     <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
        end else begin
            div       <= div_next;
            VGA_Clock <= (div_next >= DW'(CLK_DIV / 2));
            if (tick) begin
                H_COUNT     <= h_next;
                V_COUNT     <= v_next;
                VGA_BLANK_N <= visible;
                VGA_R       <= visible ? src_r : '0;
                VGA_G       <= visible ? src_g : '0;
                VGA_B       <= visible ? src_b : '0;
                VGA_HS      <= hs_act ? HS_POL : ~HS_POL;
                VGA_VS      <= vs_act ? VS_POL : ~VS_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster.
// A reference model derives every expected output from the count of clock edges
// since the last reset; the monitor compares the DUT against it each cycle.

module tb_vga_timing_gen;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CW      = 8;
    localparam int unsigned H_ACT   = 32;
    localparam int unsigned H_FP    = 4;
    localparam int unsigned H_SYNC  = 6;
    localparam int unsigned H_BP    = 6;
    localparam int unsigned V_ACT   = 16;
    localparam int unsigned V_FP    = 2;
    localparam int unsigned V_SYNC  = 3;
    localparam int unsigned V_BP    = 4;
    localparam bit          HS_POL  = 1'b0;
    localparam bit          VS_POL  = 1'b0;
    localparam int unsigned H_TOT   = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT   = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOT);
    localparam int unsigned VW      = $clog2(V_TOT);
    localparam int unsigned FRAME   = H_TOT * V_TOT * CLK_DIV;

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          vclk;
        logic          hs;
        logic          vs;
        logic          blank_n;
        logic          sync_n;
        logic          pe;
        logic          ls;
        logic          fs;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] r_in = '0;
    logic [CW-1:0] g_in = '0;
    logic [CW-1:0] b_in = '0;
    logic          pattern_sel = 1'b0;
    logic [CW-1:0] vga_r, vga_g, vga_b;
    logic          vga_clock, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          pixel_en, line_start, frame_start;

    int   vectors    = 0;
    int   miscompares = 0;
    obs_t exp_q[$];

    // Model state: edges since reset plus the video values latched on the last tick
    int            cyc = 0;
    logic [CW-1:0] m_r = '0, m_g = '0, m_b = '0;
    logic          m_hs = 1'b1, m_vs = 1'b1, m_blank = 1'b0;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .CW(CW),
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .FPGA_Clock (clk),
        .reset      (reset),
        .R          (r_in),
        .G          (g_in),
        .B          (b_in),
        .pattern_sel(pattern_sel),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .VGA_Clock  (vga_clock),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_SYNC_N (vga_sync_n),
        .H_COUNT    (h_count),
        .V_COUNT    (v_count),
        .pixel_en   (pixel_en),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic int cur_h(input int c);
        return (c / CLK_DIV) % H_TOT;
    endfunction

    function automatic int cur_v(input int c);
        return ((c / CLK_DIV) / H_TOT) % V_TOT;
    endfunction

    // Drive one cycle of inputs and push what the DUT must show after the next edge
    task automatic step(input bit rst, input logic [CW-1:0] r, input logic [CW-1:0] g,
                        input logic [CW-1:0] b, input bit ps);
        obs_t          e;
        int            ph, pv, bar, d;
        logic [2:0]    rgb_on;
        logic [CW-1:0] cr, cg, cb;
        logic [2:0]    bars [8];
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        reset = rst; r_in = r; g_in = g; b_in = b; pattern_sel = ps;
        if (rst) begin
            cyc = 0;
            m_r = '0; m_g = '0; m_b = '0;
            m_blank = 1'b0; m_hs = ~HS_POL; m_vs = ~VS_POL;
        end else begin
            if ((cyc + 1) % CLK_DIV == 0) begin
                ph = cur_h(cyc);
                pv = cur_v(cyc);
                cr = r; cg = g; cb = b;
`ifdef VGA_TEST_PATTERN_EN
                if (ps) begin
                    bar = ph / (H_ACT / 8);
                    if (bar > 7) bar = 7;
                    rgb_on = bars[bar];
                    cr = rgb_on[2] ? '1 : '0;
                    cg = rgb_on[1] ? '1 : '0;
                    cb = rgb_on[0] ? '1 : '0;
                end
`else
                bar = 0;
                rgb_on = bars[bar];
`endif
                m_blank = (ph < H_ACT) && (pv < V_ACT);
                m_hs = (ph >= H_ACT + H_FP && ph < H_ACT + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
                m_vs = (pv >= V_ACT + V_FP && pv < V_ACT + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
                m_r = m_blank ? cr : '0;
                m_g = m_blank ? cg : '0;
                m_b = m_blank ? cb : '0;
            end
            cyc++;
        end
        d         = cyc % CLK_DIV;
        e.r       = m_r;
        e.g       = m_g;
        e.b       = m_b;
        e.h       = HW'(cur_h(cyc));
        e.v       = VW'(cur_v(cyc));
        e.vclk    = (d >= CLK_DIV / 2);
        e.hs      = m_hs;
        e.vs      = m_vs;
        e.blank_n = m_blank;
        e.sync_n  = m_hs & m_vs;
        e.pe      = (d == CLK_DIV - 1);
        e.ls      = e.pe && (cur_h(cyc) == 0);
        e.fs      = e.ls && (cur_v(cyc) == 0);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_random(input int n, input bit rand_ps);
        for (int i = 0; i < n; i++) begin
            step(1'b0, CW'($urandom), CW'($urandom), CW'($urandom),
                 rand_ps ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    // Monitor: one scoreboard entry per DUT edge, sampled 1 time unit after it
    always @(posedge clk) begin
        obs_t a, e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{vga_r, vga_g, vga_b, h_count, v_count, vga_clock, vga_hs, vga_vs,
                  vga_blank_n, vga_sync_n, pixel_en, line_start, frame_start};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t got rgb=%h/%h/%h h=%0d v=%0d clk=%b hs=%b vs=%b bn=%b sn=%b pe=%b ls=%b fs=%b | exp rgb=%h/%h/%h h=%0d v=%0d clk=%b hs=%b vs=%b bn=%b sn=%b pe=%b ls=%b fs=%b",
                         vectors, $time, a.r, a.g, a.b, a.h, a.v, a.vclk, a.hs, a.vs,
                         a.blank_n, a.sync_n, a.pe, a.ls, a.fs,
                         e.r, e.g, e.b, e.h, e.v, e.vclk, e.hs, e.vs,
                         e.blank_n, e.sync_n, e.pe, e.ls, e.fs);
            end
        end
    end

    initial begin
        int guard;
        @(negedge clk);
        // Reset for 5 clocks, then free-run with random colour
        repeat (5) step(1'b1, '0, '0, '0, 1'b0);
        run_random(2 * FRAME + 100, 1'b0);
        // Constant white: visible area full scale, blanked area zero
        for (int i = 0; i < FRAME; i++) step(1'b0, '1, '1, '1, 1'b0);
        // Reset in mid-frame at a known pixel
        guard = 0;
        while (!(cur_h(cyc) == 20 && cur_v(cyc) == 10 && cyc % CLK_DIV == 0) && guard < 2 * FRAME) begin
            step(1'b0, CW'($urandom), CW'($urandom), CW'($urandom), 1'b0);
            guard++;
        end
        step(1'b1, '0, '0, '0, 1'b0);
        run_random(3 * CLK_DIV, 1'b0);
        // Test pattern request with black input
        for (int i = 0; i < FRAME; i++) step(1'b0, '0, '0, '0, 1'b1);
        // Random traffic with occasional short resets and pattern toggling
        for (int i = 0; i < 12; i++) begin
            run_random(int'($urandom_range(50, 600)), 1'b1);
            repeat (int'($urandom_range(1, 3))) step(1'b1, CW'($urandom), CW'($urandom), CW'($urandom), 1'b0);
        end
        run_random(200, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
